// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the SDRAM two-port arbiter.
// Tags identify which requester owns each outstanding read return.
package sdram_arb_pkg;

  typedef enum logic [1:0] {S_IDLE, S_VGA, S_GPU} arb_state_t;

  typedef logic src_tag_t;
  localparam src_tag_t TAG_VGA = 1'b0;
  localparam src_tag_t TAG_GPU = 1'b1;

  localparam int DEF_MAX_OUTSTANDING = 16;
  localparam int DEF_STARVE_LIMIT    = 8;

endpackage

// File: rtl/sdram_arbiter_tag_fifo.sv
// Synchronous tag FIFO; head is combinational, push/pop take effect at the clock edge.
// Push while full is accepted only with a same-cycle pop; push+pop while empty cancels out.
module tag_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // An entry pushed and popped in the same cycle on an empty FIFO never needs storing.
  assign do_push = push && !(pop && empty) && (!full || pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-requester SDRAM Avalon arbiter: 1-cycle request-to-m_* latency, 0-cycle return routing.
// Holds m_* while m_waitrequest is high; reads gated by outstanding count, GPU anti-starvation.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W          = 26,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int STARVE_LIMIT    = DEF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] vga_address,
  input  logic              vga_read,
  output logic              vga_waitrequest,
  output logic [DATA_W-1:0] vga_readdata,
  output logic              vga_readdatavalid,
  input  logic [ADDR_W-1:0] gpu_address,
  input  logic              gpu_read,
  input  logic              gpu_write,
  input  logic [DATA_W-1:0] gpu_writedata,
  output logic              gpu_waitrequest,
  output logic [DATA_W-1:0] gpu_readdata,
  output logic              gpu_readdatavalid,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic              m_write,
  output logic [DATA_W-1:0] m_writedata,
  input  logic              m_waitrequest,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_readdatavalid,
  output logic              rsp_error
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_t    state;
  logic [CW-1:0] out_cnt;
  logic [SW-1:0] starve_cnt;

  src_tag_t fifo_head;
  src_tag_t push_tag;
  src_tag_t ret_tag;
  logic     fifo_full;
  logic     fifo_empty;

  logic slot_free;
  logic ret_fifo;
  logic ret_bypass;
  logic ret_valid;
  logic read_ok;
  logic vga_elig;
  logic gpu_elig;
  logic gpu_req;
  logic gpu_win;
  logic vga_win;
  logic cap_read;

  assign slot_free = (state == S_IDLE) || !m_waitrequest;
  assign ret_fifo  = m_readdatavalid && !fifo_empty;
  // A return in the same cycle frees a slot, so a blocked read may be captured immediately.
  assign read_ok   = ((out_cnt < CW'(MAX_OUTSTANDING)) && !fifo_full) || ret_fifo;
  assign vga_elig  = vga_read && read_ok;
  assign gpu_elig  = gpu_write || (gpu_read && read_ok);
  assign gpu_req   = gpu_read || gpu_write;

  assign gpu_win  = reset && slot_free && gpu_elig &&
                    (!vga_elig || (starve_cnt == SW'(STARVE_LIMIT)));
  assign vga_win  = reset && slot_free && vga_elig && !gpu_win;
  assign cap_read = vga_win || (gpu_win && gpu_read);
  assign push_tag = gpu_win ? TAG_GPU : TAG_VGA;

  assign ret_bypass = m_readdatavalid && fifo_empty && cap_read;
  assign ret_valid  = ret_fifo || ret_bypass;
  assign ret_tag    = fifo_empty ? push_tag : fifo_head;

  assign vga_waitrequest   = !vga_win;
  assign gpu_waitrequest   = !gpu_win;
  assign vga_readdata      = m_readdata;
  assign gpu_readdata      = m_readdata;
  assign vga_readdatavalid = ret_valid && (ret_tag == TAG_VGA);
  assign gpu_readdatavalid = ret_valid && (ret_tag == TAG_GPU);

  tag_fifo #(
    .WIDTH (1),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cap_read),
    .push_data (push_tag),
    .pop       (m_readdatavalid),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      m_address   <= '0;
      m_read      <= 1'b0;
      m_write     <= 1'b0;
      m_writedata <= '0;
      out_cnt     <= '0;
      starve_cnt  <= '0;
      rsp_error   <= 1'b0;
    end else begin
      if (slot_free) begin
        if (gpu_win) begin
          m_address   <= gpu_address;
          m_read      <= gpu_read;
          m_write     <= gpu_write;
          m_writedata <= gpu_writedata;
          state       <= S_GPU;
        end else if (vga_win) begin
          m_address <= vga_address;
          m_read    <= 1'b1;
          m_write   <= 1'b0;
          state     <= S_VGA;
        end else begin
          m_read  <= 1'b0;
          m_write <= 1'b0;
          state   <= S_IDLE;
        end
      end

      if (gpu_win) begin
        starve_cnt <= '0;
      end else if (gpu_req && (starve_cnt != SW'(STARVE_LIMIT))) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      case ({cap_read, ret_valid})
        2'b10:   out_cnt <= out_cnt + 1'b1;
        2'b01:   out_cnt <= out_cnt - 1'b1;
        default: out_cnt <= out_cnt;
      endcase

      if (m_readdatavalid && !ret_valid) begin
        rsp_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a 3-stage SDRAM read-return model that can be switched off.
module tb_sdram_arbiter;

  logic        clk;
  logic        reset;
  logic [25:0] vga_address;
  logic        vga_read;
  logic        vga_waitrequest;
  logic [31:0] vga_readdata;
  logic        vga_readdatavalid;
  logic [25:0] gpu_address;
  logic        gpu_read;
  logic        gpu_write;
  logic [31:0] gpu_writedata;
  logic        gpu_waitrequest;
  logic [31:0] gpu_readdata;
  logic        gpu_readdatavalid;
  logic [25:0] m_address;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic        m_waitrequest;
  logic [31:0] m_readdata;
  logic        m_readdatavalid;
  logic        rsp_error;

  logic        model_en;
  logic        man_rdv;
  logic [31:0] man_dat;
  logic [2:0]  pipe_v;
  logic [31:0] pipe_d [3];

  logic [31:0] vga_got [$];
  logic [31:0] gpu_got [$];

  int n_checks = 0;
  int n_pass   = 0;

  sdram_arbiter dut (
    .clk               (clk),
    .reset             (reset),
    .vga_address       (vga_address),
    .vga_read          (vga_read),
    .vga_waitrequest   (vga_waitrequest),
    .vga_readdata      (vga_readdata),
    .vga_readdatavalid (vga_readdatavalid),
    .gpu_address       (gpu_address),
    .gpu_read          (gpu_read),
    .gpu_write         (gpu_write),
    .gpu_writedata     (gpu_writedata),
    .gpu_waitrequest   (gpu_waitrequest),
    .gpu_readdata      (gpu_readdata),
    .gpu_readdatavalid (gpu_readdatavalid),
    .m_address         (m_address),
    .m_read            (m_read),
    .m_write           (m_write),
    .m_writedata       (m_writedata),
    .m_waitrequest     (m_waitrequest),
    .m_readdata        (m_readdata),
    .m_readdatavalid   (m_readdatavalid),
    .rsp_error         (rsp_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SDRAM model: returns {6'b101000, address} a fixed number of cycles after acceptance.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_v <= '0;
    end else begin
      pipe_v    <= {pipe_v[1:0], m_read && !m_waitrequest};
      pipe_d[0] <= {6'b101000, m_address};
      pipe_d[1] <= pipe_d[0];
      pipe_d[2] <= pipe_d[1];
    end
  end

  assign m_readdatavalid = model_en ? pipe_v[2]  : man_rdv;
  assign m_readdata      = model_en ? pipe_d[2] : man_dat;

  always @(negedge clk) begin
    if (vga_readdatavalid) vga_got.push_back(vga_readdata);
    if (gpu_readdatavalid) gpu_got.push_back(gpu_readdata);
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int gpu_g;
    int vga_g;
    int first_gpu;
    int grants;
    int n_ret;
    logic [31:0] exp_d [3];

    reset = 1'b0;
    vga_address = '0; vga_read = 1'b0;
    gpu_address = '0; gpu_read = 1'b0; gpu_write = 1'b0; gpu_writedata = '0;
    m_waitrequest = 1'b0;
    model_en = 1'b1; man_rdv = 1'b0; man_dat = '0;

    // Reset values, including waitrequest held high with a pending request
    #2;
    vga_read = 1'b1;
    #1;
    check("rst_m_read", m_read, 0);
    check("rst_m_write", m_write, 0);
    check("rst_m_address", m_address, 0);
    check("rst_m_writedata", m_writedata, 0);
    check("rst_vga_wr", vga_waitrequest, 1);
    check("rst_gpu_wr", gpu_waitrequest, 1);
    check("rst_vga_rdv", vga_readdatavalid, 0);
    check("rst_rsp_error", rsp_error, 0);
    vga_read = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();

    // Three back-to-back VGA reads
    vga_read = 1'b1; vga_address = 26'h100;
    #3 check("t1_grant0", vga_waitrequest, 0);
    tick(); vga_address = 26'h108;
    #3 check("t1_mread0", m_read, 1);
    check("t1_addr0", m_address, 26'h100);
    check("t1_grant1", vga_waitrequest, 0);
    tick(); vga_address = 26'h110;
    #3 check("t1_mread1", m_read, 1);
    check("t1_addr1", m_address, 26'h108);
    tick(); vga_read = 1'b0;
    #3 check("t1_mread2", m_read, 1);
    check("t1_addr2", m_address, 26'h110);
    tick();
    #3 check("t1_mread_end", m_read, 0);
    repeat (8) tick();
    exp_d[0] = 32'hA000_0100; exp_d[1] = 32'hA000_0108; exp_d[2] = 32'hA000_0110;
    check("t1_vga_n", vga_got.size(), 3);
    check("t1_gpu_n", gpu_got.size(), 0);
    for (int i = 0; i < 3 && i < vga_got.size(); i++) check("t1_data", vga_got[i], exp_d[i]);
    check("t1_rsp_error", rsp_error, 0);

    // Starvation: continuous VGA reads and GPU writes for 90 cycles
    vga_got.delete(); gpu_got.delete();
    vga_read = 1'b1; vga_address = 26'h200;
    gpu_write = 1'b1; gpu_address = 26'h1000; gpu_writedata = 32'h1234_5678;
    gpu_g = 0; vga_g = 0; first_gpu = 0;
    for (int c = 1; c <= 90; c++) begin
      #3;
      if (!gpu_waitrequest) begin
        gpu_g++;
        if (first_gpu == 0) first_gpu = c;
      end
      if (!vga_waitrequest) vga_g++;
      if (c == 10) check("t2_vga_resumes", vga_waitrequest, 0);
      tick();
    end
    vga_read = 1'b0; gpu_write = 1'b0;
    check("t2_first_gpu", first_gpu, 9);
    check("t2_gpu_grants", gpu_g, 10);
    check("t2_vga_grants", vga_g, 80);
    repeat (8) tick();
    check("t2_vga_rets", vga_got.size(), 80);
    vga_got.delete(); gpu_got.delete();

    // SDRAM stall after a GPU write
    gpu_write = 1'b1; gpu_address = 26'h2000; gpu_writedata = 32'hDEAD_BEEF;
    #3 check("t3_grant", gpu_waitrequest, 0);
    tick();
    gpu_write = 1'b0; m_waitrequest = 1'b1;
    vga_read = 1'b1; vga_address = 26'h300;
    for (int c = 0; c < 5; c++) begin
      #3;
      check("t3_addr", m_address, 26'h2000);
      check("t3_write", m_write, 1);
      check("t3_wdata", m_writedata, 32'hDEAD_BEEF);
      check("t3_gpu_wr", gpu_waitrequest, 1);
      check("t3_vga_wr", vga_waitrequest, 1);
      tick();
    end
    m_waitrequest = 1'b0;
    #3 check("t3_vga_grant", vga_waitrequest, 0);
    tick(); vga_read = 1'b0;
    #3 check("t3_mread", m_read, 1);
    check("t3_maddr", m_address, 26'h300);
    check("t3_mwrite", m_write, 0);
    repeat (8) tick();
    check("t3_vga_rets", vga_got.size(), 1);
    vga_got.delete(); gpu_got.delete();

    // Outstanding limit
    model_en = 1'b0;
    vga_read = 1'b1; vga_address = 26'h400;
    grants = 0;
    for (int c = 0; c < 16; c++) begin
      #3 if (!vga_waitrequest) grants++;
      tick();
    end
    check("t4_grants", grants, 16);
    gpu_write = 1'b1; gpu_address = 26'h3000; gpu_writedata = 32'h0BAD_F00D;
    #3 check("t4_vga_stall", vga_waitrequest, 1);
    check("t4_gpu_write", gpu_waitrequest, 0);
    tick(); gpu_write = 1'b0;
    #3 check("t4_vga_stall2", vga_waitrequest, 1);
    check("t4_mwrite", m_write, 1);
    tick(); man_rdv = 1'b1; man_dat = 32'h55;
    #3 check("t4_ret_vga", vga_readdatavalid, 1);
    check("t4_same_cycle_grant", vga_waitrequest, 0);
    tick(); vga_read = 1'b0;
    n_ret = 0;
    for (int c = 0; c < 16; c++) begin
      #3 if (vga_readdatavalid) n_ret++;
      tick();
    end
    man_rdv = 1'b0;
    check("t4_drain", n_ret, 16);
    check("t4_rsp_error", rsp_error, 0);
    vga_got.delete(); gpu_got.delete();

    // Interleaved VGA/GPU reads with returns overlapping captures
    vga_read = 1'b1; vga_address = 26'h10;
    #3 check("t5_a_grant", vga_waitrequest, 0);
    tick(); vga_read = 1'b0; gpu_read = 1'b1; gpu_address = 26'h20;
    #3 check("t5_b_grant", gpu_waitrequest, 0);
    tick(); gpu_read = 1'b0; vga_read = 1'b1; vga_address = 26'h30;
    man_rdv = 1'b1; man_dat = 32'h1;
    #3 check("t5_c_vrdv", vga_readdatavalid, 1);
    check("t5_c_grdv", gpu_readdatavalid, 0);
    check("t5_c_grant", vga_waitrequest, 0);
    check("t5_c_data", vga_readdata, 32'h1);
    tick(); vga_read = 1'b0; gpu_read = 1'b1; gpu_address = 26'h40; man_dat = 32'h2;
    #3 check("t5_d_grdv", gpu_readdatavalid, 1);
    check("t5_d_vrdv", vga_readdatavalid, 0);
    check("t5_d_grant", gpu_waitrequest, 0);
    check("t5_d_data", gpu_readdata, 32'h2);
    tick(); gpu_read = 1'b0; man_dat = 32'h3;
    #3 check("t5_e_vrdv", vga_readdatavalid, 1);
    check("t5_e_grdv", gpu_readdatavalid, 0);
    tick(); man_dat = 32'h4;
    #3 check("t5_f_grdv", gpu_readdatavalid, 1);
    check("t5_f_vrdv", vga_readdatavalid, 0);
    tick(); man_dat = 32'h5;
    #3 check("t5_g_vrdv", vga_readdatavalid, 0);
    check("t5_g_grdv", gpu_readdatavalid, 0);
    check("t5_g_err_pre", rsp_error, 0);
    tick(); man_rdv = 1'b0;
    #3 check("t5_err_set", rsp_error, 1);
    repeat (3) tick();
    check("t5_err_sticky", rsp_error, 1);

    // Reset mid-burst
    model_en = 1'b1;
    vga_read = 1'b1; vga_address = 26'h500;
    repeat (3) tick();
    reset = 1'b0; vga_read = 1'b0;
    #1;
    check("t6_m_read", m_read, 0);
    check("t6_m_address", m_address, 0);
    check("t6_rsp_error", rsp_error, 0);
    check("t6_vga_wr", vga_waitrequest, 1);
    check("t6_gpu_wr", gpu_waitrequest, 1);
    check("t6_vga_rdv", vga_readdatavalid, 0);
    tick(); reset = 1'b1;
    repeat (4) tick();
    vga_got.delete(); gpu_got.delete();
    vga_read = 1'b1; vga_address = 26'h40;
    #3 check("t6_post_grant", vga_waitrequest, 0);
    tick(); vga_read = 1'b0;
    repeat (8) tick();
    check("t6_post_n", vga_got.size(), 1);
    if (vga_got.size() > 0) check("t6_post_data", vga_got[0], 32'hA000_0040);
    check("t6_post_err", rsp_error, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
